branch_group_select: RTL and testbench
======================================

# branch_group_select

Parametrised successor to the fixed four-slot fetch-group branch selector. It takes one fetch group of `GROUP_SIZE` instructions per handshake from the IF stage, with per-slot enables and predicted taken/target, and picks the first enabled predicted-taken slot. It trims the enable mask to that branch plus its delay slot and produces the next-fetch PC. It is registered with a valid/ready output, and it carries a pending delay slot across group boundaries when the taken branch sits in the last slot.

## Interface
- `GROUP_SIZE`, 4: slots per fetch group; power of two, 2..8.
- `PC_WIDTH`, 32: PC/target width.
- `DS_MODE`, 1: 1 = MIPS branch delay slot honoured; 0 = no delay slot, cut right after the branch.
- `clk` in 1: single clock.
- `rst_n` in 1: synchronous, active-low reset.
- `flush_i` in 1: synchronous pipeline flush from a backend redirect.
- `in_valid_i` in 1: input group valid.
- `in_ready_o` out 1: block can accept a group.
- `group_pc_i` in PC_WIDTH: PC of slot 0; aligned to GROUP_SIZE*4.
- `origin_enable_i` in GROUP_SIZE: slots holding real instructions.
- `pred_take_i` in GROUP_SIZE: per-slot predicted taken.
- `pred_dest_i` in GROUP_SIZE*PC_WIDTH: per-slot predicted target; slot i is at bits [i*PC_WIDTH +: PC_WIDTH].
- `out_valid_o` out 1: result valid.
- `out_ready_i` in 1: downstream accepts the result.
- `actual_enable_o` out GROUP_SIZE: trimmed enable mask.
- `first_take_o` out GROUP_SIZE: one-hot mask of the selected branch; zero if none.
- `valid_take_o` out 1: the group redirects the fetch.
- `next_pc_o` out PC_WIDTH: next fetch PC.
- `ds_pending_o` out 1: FSM is in WAIT_DS.

## Operation
- **Branch selection.** For each slot, `t[i] = pred_take_i[i] & origin_enable_i[i]`. The lowest set `t[k]` is selected and `first_take_o = onehot(k)`.
- **Enable trimming, DS_MODE=1.** `actual_enable_o = origin_enable_i & mask(0..min(k+1, N-1))`.
- **Enable trimming, DS_MODE=0.** `actual_enable_o = origin_enable_i & mask(0..k)`.
- **No branch selected.** `actual_enable_o = origin_enable_i`, `valid_take_o = 0`, `next_pc_o = group_pc_i + GROUP_SIZE*4`. The sum wraps modulo 2^PC_WIDTH.
- **Branch selected, delay slot in group.** Applies when k < N-1, or when DS_MODE=0. Then `valid_take_o = 1` and `next_pc_o = pred_dest[k]`.
- **Branch selected, DS_MODE=1 and k = N-1.** The delay slot is in the next group:
  - `valid_take_o = 0`.
  - `next_pc_o = group_pc_i + GROUP_SIZE*4`, so the delay slot group is fetched.
  - `pred_dest[k]` is latched into `held_dest`.
  - The FSM goes to WAIT_DS.
- **FSM states.** IDLE and WAIT_DS.
- **IDLE.** Behaves as described above.
- **WAIT_DS, on accepting a group:**
  - All predictions in the group are ignored; `first_take_o = 0`.
  - If `origin_enable_i[0] = 1`: `actual_enable_o = 'b1`, `valid_take_o = 1`, `next_pc_o = held_dest`, and the FSM returns to IDLE.
  - If `origin_enable_i[0] = 0`: `actual_enable_o = 0`, `valid_take_o = 0`, `next_pc_o = group_pc_i + GROUP_SIZE*4`, and the FSM stays in WAIT_DS.
- **Flush.** `flush_i` has priority over everything. It clears `out_valid_o`, sets the FSM to IDLE, clears `held_dest`, and drops any group presented in that cycle.

## Timing
- **Latency.** One cycle. A group accepted at edge n (`in_valid_i & in_ready_o`) appears on the outputs after edge n, with `out_valid_o = 1`.
- **Ready.** `in_ready_o = !out_valid_o | out_ready_i`. This is a full-throughput single register; there is no combinational path from `in_valid_i` to `out_valid_o`.
- **Stall.** While `out_valid_o & !out_ready_i`, all outputs hold stable and the FSM does not advance.
- **Drain.** `out_valid_o` falls after a handshake with no new group accepted.
- **Register updates.** The FSM and `held_dest` update only on an input handshake, or on flush/reset.
- **Reset.** With `rst_n = 0` at an edge, all outputs are 0 after that edge, the FSM is IDLE, and `held_dest` is 0. Reset overrides flush and any handshake.
- **Flush and input in the same cycle.** The group is dropped and `out_valid_o = 0` on the next cycle.

## Structure
- The following belong in the shared package / `MyDefines.v`:
  - Default `GROUP_SIZE`.
  - The slot-mask helper macro `mask(0..j)`.
  - The FSM state encoding: IDLE = 1'b0, WAIT_DS = 1'b1.
  - The existing `UNPACK_ARRAY` macro, used for `pred_dest_i`.
- One combinational sub-module: `first_take_onehot`, a parametrised lowest-set-bit priority one-hot encoder (N in, N out). It is reused for the `first_take_o` mask.
- The top level holds the FSM, `held_dest`, and the output register.

## Test plan
1. **Mid-group branch.** N=4, DS_MODE=1, pc=0x1000, enable=1111, take=0010, dest1=0x2000 -> next cycle enable=0111, first_take=0010, take=1, next_pc=0x2000.
2. **No branch.** enable=1111, take=0000, pc=0x1000 -> enable=1111, take=0, next_pc=0x1010.
3. **Cross-group delay slot.**
   - Group 1: take=1000, dest3=0x3000 -> enable=1111, take=0, next_pc=0x1010, ds_pending=1.
   - Group 2: pc=0x1010, enable=1111, take=0001 -> enable=0001, first_take=0000, take=1, next_pc=0x3000, ds_pending=0.
4. **Backpressure, then flush.** Hold `out_ready_i = 0` for 3 cycles -> outputs stable and `in_ready_o = 0`. Then assert flush during WAIT_DS -> out_valid=0, ds_pending=0. The next group is treated as IDLE.
5. **No delay slot, wide group.** N=8, DS_MODE=0, enable=11111111, take=00100100, dest2=0x4000 -> enable=00000111, first_take=00000100, next_pc=0x4000.
6. **Wrap and reset.**
   - pc=0xFFFFFFF0, N=4, no branch -> next_pc=0x00000000.
   - `rst_n = 0` mid-stream -> all outputs 0 next cycle.

Source files
------------

// File: rtl/branch_group_select_pkg.sv
// Shared definitions for the fetch-group branch selector: default group size,
// delay-slot FSM encoding and the leading slot-mask helper.
package branch_group_select_pkg;

   localparam int DEFAULT_GROUP_SIZE = 4;
   localparam int MAX_GROUP_SIZE     = 8;

   typedef enum logic {
      IDLE    = 1'b0,
      WAIT_DS = 1'b1
   } dsState_t;

   // Bits 0..lastSlot set; callers truncate to their group width.
   function automatic logic [MAX_GROUP_SIZE-1:0] slotMask(input int lastSlot);
      logic [MAX_GROUP_SIZE-1:0] m;
      for (int i = 0; i < MAX_GROUP_SIZE; i++) begin
         m[i] = (i <= lastSlot);
      end
      return m;
   endfunction

endpackage

// File: rtl/first_take_onehot.sv
// Lowest-set-bit priority encoder producing a one-hot grant (zero when no request).
module first_take_onehot #(
   parameter int N = 4
) (
   input  logic [N-1:0] req,
   output logic [N-1:0] grant
);

   // Two's-complement isolates the lowest set bit.
   assign grant = req & (~req + N'(1));

endmodule

// File: rtl/branch_group_select.sv
// Picks the first predicted-taken slot of a fetch group, trims the enable mask
// and registers the next-fetch PC, carrying a last-slot delay slot into the next group.
module branch_group_select
   import branch_group_select_pkg::*;
#(
   parameter int GROUP_SIZE = DEFAULT_GROUP_SIZE,
   parameter int PC_WIDTH   = 32,
   parameter int DS_MODE    = 1
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           flush_i,
   input  logic                           in_valid_i,
   output logic                           in_ready_o,
   input  logic [PC_WIDTH-1:0]            group_pc_i,
   input  logic [GROUP_SIZE-1:0]          origin_enable_i,
   input  logic [GROUP_SIZE-1:0]          pred_take_i,
   input  logic [GROUP_SIZE*PC_WIDTH-1:0] pred_dest_i,
   output logic                           out_valid_o,
   input  logic                           out_ready_i,
   output logic [GROUP_SIZE-1:0]          actual_enable_o,
   output logic [GROUP_SIZE-1:0]          first_take_o,
   output logic                           valid_take_o,
   output logic [PC_WIDTH-1:0]            next_pc_o,
   output logic                           ds_pending_o
);

   logic [PC_WIDTH-1:0]   predDest [GROUP_SIZE];
   logic [GROUP_SIZE-1:0] takeReq_p0;
   logic [GROUP_SIZE-1:0] firstTake_p0;
   logic [PC_WIDTH-1:0]   selDest_p0;
   int                    selIdx_p0;
   int                    trimEnd_p0;
   logic [PC_WIDTH-1:0]   seqPc_p0;
   logic [GROUP_SIZE-1:0] enable_p0;
   logic [GROUP_SIZE-1:0] firstOut_p0;
   logic                  validTake_p0;
   logic [PC_WIDTH-1:0]   nextPc_p0;
   dsState_t              state_p0;
   logic [PC_WIDTH-1:0]   heldDest_p0;

   logic                  vld_p1;
   logic [GROUP_SIZE-1:0] actualEnable_p1;
   logic [GROUP_SIZE-1:0] firstTake_p1;
   logic                  validTake_p1;
   logic [PC_WIDTH-1:0]   nextPc_p1;
   dsState_t              state_p1;
   logic [PC_WIDTH-1:0]   heldDest_p1;
   logic                  accept;

   for (genvar g = 0; g < GROUP_SIZE; g++) begin : gUnpack
      assign predDest[g] = pred_dest_i[g*PC_WIDTH +: PC_WIDTH];
   end

   assign takeReq_p0 = pred_take_i & origin_enable_i;

   first_take_onehot #(.N(GROUP_SIZE)) uFirstTake (
      .req   (takeReq_p0),
      .grant (firstTake_p0)
   );

   // Stage p0: selection, trimming and next-PC decision.
   always_comb begin
      selDest_p0 = '0;
      selIdx_p0  = 0;
      for (int i = 0; i < GROUP_SIZE; i++) begin
         if (firstTake_p0[i]) begin
            selDest_p0 = predDest[i];
            selIdx_p0  = i;
         end
      end
      if (DS_MODE != 0) begin
         trimEnd_p0 = (selIdx_p0 + 1 > GROUP_SIZE - 1) ? GROUP_SIZE - 1 : selIdx_p0 + 1;
      end else begin
         trimEnd_p0 = selIdx_p0;
      end
      seqPc_p0     = group_pc_i + PC_WIDTH'(GROUP_SIZE * 4);
      enable_p0    = origin_enable_i;
      firstOut_p0  = '0;
      validTake_p0 = 1'b0;
      nextPc_p0    = seqPc_p0;
      state_p0     = state_p1;
      heldDest_p0  = heldDest_p1;

      if (state_p1 == WAIT_DS) begin
         // Slot 0 of this group is the pending delay slot; predictions are ignored.
         if (origin_enable_i[0]) begin
            enable_p0    = GROUP_SIZE'(1);
            validTake_p0 = 1'b1;
            nextPc_p0    = heldDest_p1;
            state_p0     = IDLE;
         end else begin
            enable_p0 = '0;
         end
      end else if (|firstTake_p0) begin
         firstOut_p0 = firstTake_p0;
         enable_p0   = origin_enable_i & GROUP_SIZE'(slotMask(trimEnd_p0));
         if (DS_MODE != 0 && selIdx_p0 == GROUP_SIZE - 1) begin
            state_p0    = WAIT_DS;
            heldDest_p0 = selDest_p0;
         end else begin
            validTake_p0 = 1'b1;
            nextPc_p0    = selDest_p0;
         end
      end
   end

   assign in_ready_o = !vld_p1 | out_ready_i;
   assign accept     = in_valid_i & in_ready_o;

   // Stage p1: output register, FSM and held target.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         vld_p1          <= 1'b0;
         actualEnable_p1 <= '0;
         firstTake_p1    <= '0;
         validTake_p1    <= 1'b0;
         nextPc_p1       <= '0;
         state_p1        <= IDLE;
         heldDest_p1     <= '0;
      end else if (flush_i) begin
         vld_p1      <= 1'b0;
         state_p1    <= IDLE;
         heldDest_p1 <= '0;
      end else if (accept) begin
         vld_p1          <= 1'b1;
         actualEnable_p1 <= enable_p0;
         firstTake_p1    <= firstOut_p0;
         validTake_p1    <= validTake_p0;
         nextPc_p1       <= nextPc_p0;
         state_p1        <= state_p0;
         heldDest_p1     <= heldDest_p0;
      end else if (out_ready_i) begin
         vld_p1 <= 1'b0;
      end
   end

   assign out_valid_o     = vld_p1;
   assign actual_enable_o = actualEnable_p1;
   assign first_take_o    = firstTake_p1;
   assign valid_take_o    = validTake_p1;
   assign next_pc_o       = nextPc_p1;
   assign ds_pending_o    = (state_p1 == WAIT_DS);

endmodule

// File: tb/tb_branch_group_select.sv
// Directed bench: N=4 with delay slot, and N=8 without delay slot.
module tb_branch_group_select;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         rstN, flush, inValid, outReady;
   logic [31:0]  pc4;
   logic [3:0]   en4, take4;
   logic [127:0] dest4;
   logic         inReady4, outValid4, validTake4, dsPending4;
   logic [3:0]   actEn4, first4;
   logic [31:0]  nextPc4;

   logic [31:0]  pc8;
   logic [7:0]   en8, take8;
   logic [255:0] dest8;
   logic         inReady8, outValid8, validTake8, dsPending8;
   logic [7:0]   actEn8, first8;
   logic [31:0]  nextPc8;

   int nChecks = 0;
   int nFails  = 0;

   branch_group_select #(.GROUP_SIZE(4), .PC_WIDTH(32), .DS_MODE(1)) dut4 (
      .clk(clk), .rst_n(rstN), .flush_i(flush), .in_valid_i(inValid), .in_ready_o(inReady4),
      .group_pc_i(pc4), .origin_enable_i(en4), .pred_take_i(take4), .pred_dest_i(dest4),
      .out_valid_o(outValid4), .out_ready_i(outReady), .actual_enable_o(actEn4),
      .first_take_o(first4), .valid_take_o(validTake4), .next_pc_o(nextPc4),
      .ds_pending_o(dsPending4)
   );

   branch_group_select #(.GROUP_SIZE(8), .PC_WIDTH(32), .DS_MODE(0)) dut8 (
      .clk(clk), .rst_n(rstN), .flush_i(flush), .in_valid_i(inValid), .in_ready_o(inReady8),
      .group_pc_i(pc8), .origin_enable_i(en8), .pred_take_i(take8), .pred_dest_i(dest8),
      .out_valid_o(outValid8), .out_ready_i(outReady), .actual_enable_o(actEn8),
      .first_take_o(first8), .valid_take_o(validTake8), .next_pc_o(nextPc8),
      .ds_pending_o(dsPending8)
   );

   task automatic checkVal(input string tag, input logic [63:0] act, input logic [63:0] exp);
      nChecks++;
      if (act !== exp) begin
         nFails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check4(input string tag, input logic vld, input logic [3:0] en,
                         input logic [3:0] ft, input logic vt, input logic [31:0] npc,
                         input logic ds);
      checkVal({tag, ".valid"}, 64'(outValid4), 64'(vld));
      checkVal({tag, ".enable"}, 64'(actEn4), 64'(en));
      checkVal({tag, ".first"}, 64'(first4), 64'(ft));
      checkVal({tag, ".take"}, 64'(validTake4), 64'(vt));
      checkVal({tag, ".nextpc"}, 64'(nextPc4), 64'(npc));
      checkVal({tag, ".ds"}, 64'(dsPending4), 64'(ds));
   endtask

   task automatic setGroup4(input logic [31:0] pc, input logic [3:0] en, input logic [3:0] tk);
      pc4   = pc;
      en4   = en;
      take4 = tk;
   endtask

   initial begin
      rstN = 1'b0; flush = 1'b0; inValid = 1'b1; outReady = 1'b1;
      setGroup4(32'h1000, 4'hF, 4'h2);
      dest4 = '0;
      pc8 = 32'h8000; en8 = 8'hFF; take8 = 8'h24; dest8 = '0;
      dest8[2*32 +: 32] = 32'h4000;
      step(); step();
      check4("reset", 1'b0, 4'h0, 4'h0, 1'b0, 32'h0, 1'b0);
      checkVal("reset.inready", 64'(inReady4), 64'd1);
      checkVal("reset8.valid", 64'(outValid8), 64'd0);

      // Mid-group branch, and the N=8 no-delay-slot cut.
      rstN = 1'b1;
      dest4[1*32 +: 32] = 32'h2000;
      step();
      check4("midgroup", 1'b1, 4'h7, 4'h2, 1'b1, 32'h2000, 1'b0);
      checkVal("wide.enable", 64'(actEn8), 64'h07);
      checkVal("wide.first", 64'(first8), 64'h04);
      checkVal("wide.take", 64'(validTake8), 64'd1);
      checkVal("wide.nextpc", 64'(nextPc8), 64'h4000);

      // No branch; N=8 branch in last slot still redirects immediately.
      setGroup4(32'h1000, 4'hF, 4'h0);
      take8 = 8'h80; dest8[7*32 +: 32] = 32'h7000;
      step();
      check4("nobranch", 1'b1, 4'hF, 4'h0, 1'b0, 32'h1010, 1'b0);
      checkVal("wide7.enable", 64'(actEn8), 64'hFF);
      checkVal("wide7.take", 64'(validTake8), 64'd1);
      checkVal("wide7.nextpc", 64'(nextPc8), 64'h7000);
      checkVal("wide7.ds", 64'(dsPending8), 64'd0);

      // Branch in slot 0 keeps slot 0 and its delay slot.
      setGroup4(32'h1000, 4'hF, 4'h1);
      dest4[0 +: 32] = 32'h5000;
      step();
      check4("slot0", 1'b1, 4'h3, 4'h1, 1'b1, 32'h5000, 1'b0);

      // Branch in slot 2: delay slot is slot 3, still inside the group.
      setGroup4(32'h1000, 4'hF, 4'h4);
      dest4[2*32 +: 32] = 32'h6000;
      step();
      check4("slot2", 1'b1, 4'hF, 4'h4, 1'b1, 32'h6000, 1'b0);

      // Cross-group delay slot.
      setGroup4(32'h1000, 4'hF, 4'h8);
      dest4[3*32 +: 32] = 32'h3000;
      step();
      check4("xgroup1", 1'b1, 4'hF, 4'h8, 1'b0, 32'h1010, 1'b1);
      setGroup4(32'h1010, 4'hF, 4'h1);
      step();
      check4("xgroup2", 1'b1, 4'h1, 4'h0, 1'b1, 32'h3000, 1'b0);

      // Enter WAIT_DS again, then a group without slot 0 keeps waiting.
      setGroup4(32'h1000, 4'hF, 4'h8);
      step();
      check4("reenter", 1'b1, 4'hF, 4'h8, 1'b0, 32'h1010, 1'b1);
      setGroup4(32'h1010, 4'hE, 4'h2);
      step();
      check4("noslot0", 1'b1, 4'h0, 4'h0, 1'b0, 32'h1020, 1'b1);

      // Backpressure: outputs hold and the input is refused.
      outReady = 1'b0;
      setGroup4(32'h2000, 4'hF, 4'h0);
      for (int c = 0; c < 3; c++) begin
         step();
         check4("stall", 1'b1, 4'h0, 4'h0, 1'b0, 32'h1020, 1'b1);
         checkVal("stall.inready", 64'(inReady4), 64'd0);
      end

      // Flush during WAIT_DS with a group presented: group dropped.
      flush = 1'b1; outReady = 1'b1;
      step();
      checkVal("flush.valid", 64'(outValid4), 64'd0);
      checkVal("flush.ds", 64'(dsPending4), 64'd0);
      flush = 1'b0;
      setGroup4(32'h1000, 4'hF, 4'h2);
      step();
      check4("postflush", 1'b1, 4'h7, 4'h2, 1'b1, 32'h2000, 1'b0);

      // Drain.
      inValid = 1'b0;
      step();
      checkVal("drain.valid", 64'(outValid4), 64'd0);

      // PC wrap.
      inValid = 1'b1;
      setGroup4(32'hFFFF_FFF0, 4'hF, 4'h0);
      step();
      check4("wrap", 1'b1, 4'hF, 4'h0, 1'b0, 32'h0, 1'b0);

      // Reset mid-stream, overriding flush and a presented group.
      setGroup4(32'h1000, 4'hF, 4'h8);
      step();
      checkVal("prereset.ds", 64'(dsPending4), 64'd1);
      rstN = 1'b0; flush = 1'b1;
      step();
      check4("midreset", 1'b0, 4'h0, 4'h0, 1'b0, 32'h0, 1'b0);
      checkVal("midreset8.nextpc", 64'(nextPc8), 64'h0);
      checkVal("midreset8.take", 64'(validTake8), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

endmodule
